// File: rtl/ram_1r1w_be_pkg.sv
// Shared types and parameter helpers for the byte-enabled simple-dual-port RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_seq_state_t;

  function automatic int num_lanes(input int data_bits, input int lane_bits);
    return data_bits / lane_bits;
  endfunction

  function automatic bit params_ok(input int data_bits, input int lane_bits,
                                   input int read_latency);
    return (lane_bits > 0) && ((data_bits % lane_bits) == 0) &&
           ((read_latency == 1) || (read_latency == 2));
  endfunction

endpackage

// File: rtl/ram_1r1w_be_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then reports READY.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_BITS      = 14,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_BITS-1:0] clr_addr
);

  ram_seq_state_t       state_r;
  logic [ADDR_BITS-1:0] cnt_r;

  // State and clear-address counter; the counter wraps to 0 after the last address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= CLEAR;
      cnt_r   <= {ADDR_BITS{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          if (!CLEAR_ON_RESET) begin
            state_r <= READY;
            cnt_r   <= {ADDR_BITS{1'b0}};
          end else if (cnt_r == {ADDR_BITS{1'b1}}) begin
            state_r <= READY;
            cnt_r   <= {ADDR_BITS{1'b0}};
          end else begin
            state_r <= CLEAR;
            cnt_r   <= cnt_r + ADDR_BITS'(1);
          end
        end
        READY: begin
          state_r <= READY;
          cnt_r   <= cnt_r;
        end
        default: begin
          state_r <= CLEAR;
          cnt_r   <= {ADDR_BITS{1'b0}};
        end
      endcase
    end
  end

  assign busy     = (state_r == CLEAR);
  assign clr_we   = (state_r == CLEAR) && CLEAR_ON_RESET;
  assign clr_addr = cnt_r;

endmodule

// File: rtl/ram_1r1w_be.sv
// Simple-dual-port RAM with per-lane write masks, 1- or 2-cycle read latency,
// selectable read-during-write policy and optional zero-fill after reset.
module ram_1r1w_be
  import ram_pkg::*;
#(
  parameter int ADDR_BITS      = 14,
  parameter int DATA_BITS      = 64,
  parameter int LANE_BITS      = 8,
  parameter int READ_LATENCY   = 1,
  parameter bit WRITE_FIRST    = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NUM_LANES     = num_lanes(DATA_BITS, LANE_BITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [NUM_LANES-1:0] wr_mask
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (!params_ok(DATA_BITS, LANE_BITS, READ_LATENCY)) begin : g_param_err
    $error("ram_1r1w_be: DATA_BITS must be a multiple of LANE_BITS and READ_LATENCY must be 1 or 2");
  end

  logic                 clr_we_s;
  logic [ADDR_BITS-1:0] clr_addr_s;
  logic                 we_s;
  logic [ADDR_BITS-1:0] waddr_s;
  logic [DATA_BITS-1:0] wdata_s;
  logic [NUM_LANES-1:0] wmask_s;
  logic                 rd_fire_s;
  logic [DATA_BITS-1:0] rd_word_s;
  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic                 v1_r;
  logic [DATA_BITS-1:0] d1_r;

  ram_clear_seq #(
    .ADDR_BITS      (ADDR_BITS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  assign rd_fire_s = rd_en && !busy;

  // Single internal write port: clear writes win, user writes only when not busy.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = wr_addr;
    wdata_s = wr_data;
    wmask_s = wr_mask;
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_s;
      wdata_s = {DATA_BITS{1'b0}};
      wmask_s = {NUM_LANES{1'b1}};
    end else if (!busy && wr_en) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Array update, lane by lane.
  always_ff @(posedge clock) begin
    if (we_s) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wmask_s[i]) begin
          mem_r[waddr_s][i*LANE_BITS +: LANE_BITS] <= wdata_s[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  // Read word, with same-cycle write merged in when the write-first policy applies.
  always_comb begin
    rd_word_s = mem_r[rd_addr];
    if (WRITE_FIRST && we_s && (waddr_s == rd_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_word_s[i*LANE_BITS +: LANE_BITS] = wmask_s[i] ? wdata_s[i*LANE_BITS +: LANE_BITS]
                                                         : mem_r[rd_addr][i*LANE_BITS +: LANE_BITS];
      end
    end else begin
      rd_word_s = mem_r[rd_addr];
    end
  end

  // First read stage; data only moves on an accepted read so it holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_r <= 1'b0;
      d1_r <= {DATA_BITS{1'b0}};
    end else begin
      v1_r <= rd_fire_s;
      if (rd_fire_s) begin
        d1_r <= rd_word_s;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                 v2_r;
    logic [DATA_BITS-1:0] d2_r;

    // Extra output stage; valid travels with the data.
    always_ff @(posedge clock) begin
      if (reset) begin
        v2_r <= 1'b0;
        d2_r <= {DATA_BITS{1'b0}};
      end else begin
        v2_r <= v1_r;
        if (v1_r) begin
          d2_r <= d1_r;
        end
      end
    end

    assign rd_valid = v2_r;
    assign rd_data  = d2_r;
  end else begin : g_lat1
    assign rd_valid = v1_r;
    assign rd_data  = d1_r;
  end

endmodule
